// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // 2'd3 is never entered; the FSM treats it as a request to return to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/half_adder.sv
// One-bit half adder: the combinational sum/carry primitive.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;

endmodule : half_adder

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders plus an OR of their carries.
module full_adder (
    input  logic i_x,
    input  logic i_y,
    input  logic i_z,
    output logic o_s,
    output logic o_c
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    half_adder u_ha0 (
        .i_a (i_x),
        .i_b (i_y),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    half_adder u_ha1 (
        .i_a (w_s1),
        .i_b (i_z),
        .o_s (o_s),
        .o_c (w_c2)
    );

    // At most one of the two stage carries can be set, so OR completes the carry.
    assign o_c = w_c1 | w_c2;

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, start/done handshake.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for START; outputs hold the last result
//   RUN   | one operand bit pair added per clock, BUSY high
//   FIN   | result just committed, DONE high; may accept a new START
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_s;
    logic             w_fa_c;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum_next;

    full_adder u_fa (
        .i_x (r_a_sr[0]),
        .i_y (r_b_sr[0]),
        .i_z (r_carry),
        .o_s (w_fa_s),
        .o_c (w_fa_c)
    );

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = i_start && ((r_state == IDLE) || (r_state == FIN));

    // New sum bit enters from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
    always_comb begin
        w_sum_next            = r_sum_sr >> 1;
        w_sum_next[WIDTH-1]   = w_fa_s;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; FIN accepts START directly so back-to-back adds have no bubble.
    always_comb begin
        w_state_next = IDLE;
        case (r_state)
            IDLE:    w_state_next = i_start ? RUN : IDLE;
            RUN:     w_state_next = w_last ? FIN : RUN;
            FIN:     w_state_next = i_start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, serial datapath and result commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sr   <= i_a;
            r_b_sr   <= i_b;
            r_carry  <= i_cin;
            r_cnt    <= '0;
            r_sum_sr <= '0;
        end else if (r_state == RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_sum_sr <= w_sum_next;
            r_carry  <= w_fa_c;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_sum_next;
                r_cout <= w_fa_c;
            end
        end
    end

    assign o_busy = (r_state == RUN);
    assign o_done = (r_state == FIN);
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int         n_chk;
    int         n_err;
    logic [7:0] model_sum;
    logic       model_cout;

    serial_adder #(.WIDTH(8)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start1),
        .i_a     (a1),
        .i_b     (b1),
        .i_cin   (cin1),
        .o_busy  (busy1),
        .o_done  (done1),
        .o_sum   (sum1),
        .o_cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One add on the 8-bit instance; optional stray START mid-RUN.
    task automatic run_add(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                           input logic tcin, input logic [7:0] es, input logic ec,
                           input bit poke);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; cin = tcin;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~ta; b = ~tb; cin = ~tcin;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_val({tag, "_busy"}, 32'(busy), 32'd1);
            check_val({tag, "_nodone"}, 32'(done), 32'd0);
            check_val({tag, "_hold_sum"}, 32'(sum), 32'(model_sum));
            check_val({tag, "_hold_cout"}, 32'(cout), 32'(model_cout));
            if (poke && k == 2) begin
                start = 1'b1; a = 8'h55; b = 8'h55; cin = 1'b1;
            end
            if (poke && k == 3) start = 1'b0;
        end
        @(negedge clk);
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_val({tag, "_busy_fin"}, 32'(busy), 32'd0);
        check_val({tag, "_sum"}, 32'(sum), 32'(es));
        check_val({tag, "_cout"}, 32'(cout), 32'(ec));
        model_sum = es;
        model_cout = ec;
        @(negedge clk);
        check_val({tag, "_done_once"}, 32'(done), 32'd0);
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        model_sum = 8'h00; model_cout = 1'b0;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;

        // Reset then idle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("rst_busy", 32'(busy), 32'd0);
            check_val("rst_done", 32'(done), 32'd0);
            check_val("rst_sum", 32'(sum), 32'h00);
            check_val("rst_cout", 32'(cout), 32'd0);
            check_val("rst_w1", 32'({busy1, done1, sum1, cout1}), 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_val("idle_busy", 32'(busy), 32'd0);
            check_val("idle_done", 32'(done), 32'd0);
        end

        run_add("basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run_add("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_add("allones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_add("ign_start", 8'h20, 8'h03, 1'b0, 8'h23, 1'b0, 1'b1);

        // Back-to-back with START held high.
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(posedge clk);
        #1;
        a = 8'h80; b = 8'h80;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_val("b2b1_busy", 32'(busy), 32'd1);
            check_val("b2b1_hold", 32'(sum), 32'(model_sum));
        end
        @(negedge clk);
        check_val("b2b1_done", 32'(done), 32'd1);
        check_val("b2b1_sum", 32'(sum), 32'h46);
        check_val("b2b1_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; a = 8'h00; b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_val("b2b2_busy", 32'(busy), 32'd1);
            check_val("b2b2_nodone", 32'(done), 32'd0);
            check_val("b2b2_hold", 32'(sum), 32'h46);
        end
        @(negedge clk);
        check_val("b2b2_done", 32'(done), 32'd1);
        check_val("b2b2_sum", 32'(sum), 32'h00);
        check_val("b2b2_cout", 32'(cout), 32'd1);
        model_sum = 8'h00; model_cout = 1'b1;
        @(negedge clk);
        check_val("b2b_end", 32'(done), 32'd0);

        // Reset in the middle of an add.
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("midrst_pre_busy", 32'(busy), 32'd1);
        check_val("midrst_pre_cout", 32'(cout), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_sum", 32'(sum), 32'h00);
        check_val("midrst_cout", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_sum = 8'h00; model_cout = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_val("midrst_nodone", 32'(done), 32'd0);
            check_val("midrst_idle", 32'(busy), 32'd0);
        end
        run_add("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // WIDTH=1 instance: 1+1+1.
        @(negedge clk);
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        @(negedge clk);
        check_val("w1_busy", 32'(busy1), 32'd1);
        check_val("w1_nodone", 32'(done1), 32'd0);
        check_val("w1_hold", 32'({sum1, cout1}), 32'd0);
        @(negedge clk);
        check_val("w1_done", 32'(done1), 32'd1);
        check_val("w1_sum", 32'(sum1), 32'd1);
        check_val("w1_cout", 32'(cout1), 32'd1);
        @(negedge clk);
        check_val("w1_done_once", 32'(done1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_serial_adder
